// File: rtl/newhope_pkg.sv
// Shared widths, FSM encoding and the seed-to-state load function for trivium_prng.
package newhope_pkg;

  localparam int TRIV_STATE_W  = 288;
  localparam int SEED_W        = 256;
  localparam int RDI_W         = 128;
  localparam int WARMUP_ROUNDS = 1152;
  localparam int KEY_W         = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    READY = 2'd2,
    GEN   = 2'd3
  } prng_state_e;

  // Fold the 256-bit seed into an 80-bit key and IV and lay them out in the
  // Trivium register. Bit i of the vector holds s(i+1); K1/IV1 land in bit 0
  // of their fields. Field order from the top:
  // s286..s288 ones, s174..s285 zero, IV, s81..s93 zero, K.
  function automatic logic [TRIV_STATE_W-1:0] trivium_load(input logic [SEED_W-1:0] seed);
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] iv;
    key = seed[79:0] ^ seed[239:160];
    iv  = seed[159:80] ^ {64'b0, seed[255:240]};
    return {3'b111, 112'b0, iv, 13'b0, key};
  endfunction

endpackage

// File: rtl/trivium_rounds.sv
// Combinational chain of UNROLL Trivium rounds; z[0] is the first keystream bit.
module trivium_rounds
  import newhope_pkg::*;
#(
  parameter int UNROLL = 64
) (
  input  logic [TRIV_STATE_W-1:0] state_in,
  output logic [TRIV_STATE_W-1:0] state_out,
  output logic [UNROLL-1:0]       z
);

  logic [TRIV_STATE_W-1:0] chain [0:UNROLL];

  assign chain[0] = state_in;

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_round
      logic [TRIV_STATE_W-1:0] s;
      logic t1a, t2a, t3a;
      logic t1, t2, t3;

      assign s   = chain[gi];
      // Linear taps feed the keystream bit before the AND feedback is mixed in.
      assign t1a = s[65] ^ s[92];
      assign t2a = s[161] ^ s[176];
      assign t3a = s[242] ^ s[287];
      assign z[gi] = t1a ^ t2a ^ t3a;

      assign t1 = t1a ^ (s[90] & s[91]) ^ s[170];
      assign t2 = t2a ^ (s[174] & s[175]) ^ s[263];
      assign t3 = t3a ^ (s[285] & s[286]) ^ s[68];

      // Each of the three sub-registers shifts up by one; s93, s177 and s288 fall off.
      assign chain[gi+1] = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
  endgenerate

  assign state_out = chain[UNROLL];

endmodule

// File: rtl/trivium_prng.sv
// Trivium keystream generator: reseed + warmup, then 128-bit words on request.
module trivium_prng
  import newhope_pkg::*;
#(
  parameter int UNROLL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] seed,
  input  logic              reseed,
  output logic              reseed_ack,
  input  logic              rdi_ready,
  output logic              rdi_valid,
  output logic [RDI_W-1:0]  rdi_data
);

  localparam int WARM_CYC = WARMUP_ROUNDS / UNROLL;
  localparam int GEN_CYC  = RDI_W / UNROLL;
  localparam int CNT_W    = $clog2(WARM_CYC + 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYC - 1);
  localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(GEN_CYC - 1);

  prng_state_e             state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    pend_reg, pend_next;
  logic [TRIV_STATE_W-1:0] triv_reg, triv_next;
  logic [RDI_W-1:0]        acc_reg, acc_next;
  logic [RDI_W-1:0]        data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic                    ack_reg, ack_next;

  logic [TRIV_STATE_W-1:0] rounds_state;
  logic [UNROLL-1:0]       rounds_z;
  logic [RDI_W-1:0]        word;

  trivium_rounds #(.UNROLL(UNROLL)) u_rounds (
    .state_in  (triv_reg),
    .state_out (rounds_state),
    .z         (rounds_z)
  );

  // Newer keystream chunks enter at the top so the first bit ends up in word[0].
  generate
    if (UNROLL == RDI_W) begin : g_word_single
      assign word = rounds_z;
    end else begin : g_word_shift
      assign word = {rounds_z, acc_reg[RDI_W-1:UNROLL]};
    end
  endgenerate

  // All state registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
      triv_reg  <= '0;
      acc_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      triv_reg  <= triv_next;
      acc_reg   <= acc_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      ack_reg   <= ack_next;
    end
  end

  // Next-state logic; reseed preempts everything and turns an in-flight word into a pending one.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    triv_next  = triv_reg;
    acc_next   = acc_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ack_next   = 1'b0;

    if (reseed) begin
      state_next = WARM;
      cnt_next   = '0;
      triv_next  = trivium_load(seed);
      pend_next  = pend_reg | rdi_ready | (state_reg == GEN);
    end else begin
      case (state_reg)
        IDLE: begin
          if (rdi_ready) pend_next = 1'b1;
        end
        WARM: begin
          triv_next = rounds_state;
          if (rdi_ready) pend_next = 1'b1;
          if (cnt_reg == WARM_LAST) begin
            state_next = READY;
            cnt_next   = '0;
            ack_next   = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        READY: begin
          if (rdi_ready || pend_reg) begin
            state_next = GEN;
            pend_next  = 1'b0;
            cnt_next   = '0;
          end
        end
        GEN: begin
          triv_next = rounds_state;
          acc_next  = word;
          if (rdi_ready) pend_next = 1'b1;
          if (cnt_reg == GEN_LAST) begin
            state_next = READY;
            cnt_next   = '0;
            data_next  = word;
            valid_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign reseed_ack = ack_reg;
  assign rdi_valid  = valid_reg;
  assign rdi_data   = data_reg;

endmodule

// File: tb/tb_trivium_prng.sv
// Directed-timing, random-seed bench for trivium_prng against a bit-array Trivium model.
module tb_trivium_prng;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] seed;
  logic         reseed;
  logic         reseed_ack;
  logic         rdi_ready;
  logic         rdi_valid;
  logic [127:0] rdi_data;

  trivium_prng #(.UNROLL(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .reseed     (reseed),
    .reseed_ack (reseed_ack),
    .rdi_ready  (rdi_ready),
    .rdi_valid  (rdi_valid),
    .rdi_data   (rdi_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scenario tables indexed by cycle number.
  bit           ready_at  [0:99];
  bit           reseed_at [0:99];
  logic [255:0] seed_at   [0:99];
  bit           vexp      [0:99];
  bit           aexp      [0:99];
  logic [127:0] last_word;

  // Reference model: Trivium register numbered s1..s288 as in the algorithm description.
  bit ms [1:288];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_round(output bit zb);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    zb = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i >= 2; i--) ms[i] = ms[i-1];
    ms[1]   = t3;
    ms[94]  = t1;
    ms[178] = t2;
  endtask

  task automatic model_seed(input logic [255:0] sd);
    bit zb;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ms[1 + i]  = sd[i] ^ sd[160 + i];
      ms[94 + i] = sd[80 + i] ^ ((i < 16) ? sd[240 + i] : 1'b0);
    end
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
    for (int r = 0; r < 1152; r++) model_round(zb);
  endtask

  task automatic model_word(output logic [127:0] w);
    bit zb;
    for (int k = 0; k < 128; k++) begin
      model_round(zb);
      w[k] = zb;
    end
  endtask

  function automatic logic [255:0] rand_seed();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic clear_tables();
    for (int i = 0; i < 100; i++) begin
      ready_at[i]  = 1'b0;
      reseed_at[i] = 1'b0;
      seed_at[i]   = '0;
      vexp[i]      = 1'b0;
      aexp[i]      = 1'b0;
    end
  endtask

  // Reset, check the cleared outputs, release; the cycle after release is cycle 0.
  task automatic do_reset();
    rst       = 1'b0;
    reseed    = 1'b0;
    rdi_ready = 1'b0;
    seed      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {127'b0, rdi_valid}, 128'd0);
    chk("reset_ack", {127'b0, reseed_ack}, 128'd0);
    chk("reset_data", rdi_data, 128'd0);
    rst       = 1'b1;
    last_word = '0;
    cyc       = 0;
  endtask

  // Walk n cycles: check outputs of the current cycle, then drive its inputs.
  task automatic run(input int n, input int rst_cyc);
    logic [127:0] w;
    for (int c = 0; c < n; c++) begin
      chk("valid", {127'b0, rdi_valid}, {127'b0, vexp[cyc]});
      chk("ack", {127'b0, reseed_ack}, {127'b0, aexp[cyc]});
      if (vexp[cyc]) begin
        model_word(w);
        last_word = w;
      end
      chk("data", rdi_data, last_word);
      if (cyc == rst_cyc) begin
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", {127'b0, rdi_valid}, 128'd0);
        chk("async_rst_ack", {127'b0, reseed_ack}, 128'd0);
        chk("async_rst_data", rdi_data, 128'd0);
        last_word = '0;
        #1 rst = 1'b1;
      end
      rdi_ready = ready_at[cyc];
      reseed    = reseed_at[cyc];
      seed      = reseed_at[cyc] ? seed_at[cyc] : rand_seed();
      if (reseed_at[cyc]) model_seed(seed_at[cyc]);
      @(posedge clk);
      #1;
      cyc++;
    end
    rdi_ready = 1'b0;
    reseed    = 1'b0;
  endtask

  initial begin
    // Zero seed, single word after warmup.
    clear_tables();
    do_reset();
    reseed_at[10] = 1'b1; seed_at[10] = '0;
    ready_at[40]  = 1'b1;
    aexp[29] = 1'b1;
    vexp[43] = 1'b1;
    run(50, -1);
    $display("scenario zero_seed done at cycle %0d", cyc);

    // Request before any seed stays pending and is served right after the first warmup.
    clear_tables();
    do_reset();
    ready_at[5]  = 1'b1;
    reseed_at[8] = 1'b1; seed_at[8] = rand_seed();
    aexp[27] = 1'b1;
    vexp[30] = 1'b1;
    run(40, -1);
    $display("scenario early_request done at cycle %0d", cyc);

    // Back-to-back: request on every valid cycle, eight consecutive words.
    clear_tables();
    do_reset();
    reseed_at[10] = 1'b1; seed_at[10] = rand_seed();
    aexp[29] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ready_at[40 + 3*k] = 1'b1;
      vexp[43 + 3*k]     = 1'b1;
    end
    run(70, -1);
    $display("scenario back_to_back done at cycle %0d", cyc);

    // Reseed during generation aborts the word and re-issues it after the new warmup.
    clear_tables();
    do_reset();
    reseed_at[10] = 1'b1; seed_at[10] = rand_seed();
    ready_at[40]  = 1'b1;
    reseed_at[41] = 1'b1; seed_at[41] = rand_seed();
    aexp[29] = 1'b1;
    aexp[60] = 1'b1;
    vexp[63] = 1'b1;
    run(70, -1);
    $display("scenario reseed_in_gen done at cycle %0d", cyc);

    // Reseed during warmup restarts it; reseed+request together leaves the request pending.
    clear_tables();
    do_reset();
    reseed_at[10] = 1'b1; seed_at[10] = rand_seed();
    reseed_at[15] = 1'b1; seed_at[15] = rand_seed();
    ready_at[15]  = 1'b1;
    ready_at[40]  = 1'b1;
    aexp[34] = 1'b1;
    vexp[37] = 1'b1;
    vexp[43] = 1'b1;
    run(50, -1);
    $display("scenario double_reseed done at cycle %0d", cyc);

    // Asynchronous reset mid-generation; afterwards requests are ignored until a reseed.
    clear_tables();
    do_reset();
    reseed_at[10] = 1'b1; seed_at[10] = rand_seed();
    ready_at[40]  = 1'b1;
    ready_at[50]  = 1'b1;
    ready_at[55]  = 1'b1;
    ready_at[60]  = 1'b1;
    aexp[29] = 1'b1;
    vexp[43] = 1'b1;
    run(80, 51);
    $display("scenario async_reset done at cycle %0d", cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trivium_prng.md
TRIVIUM_PRNG -- requirements
Module: trivium_prng

Interface
REQ-001 SHALL have parameter UNROLL, default 64, meaning Trivium rounds per clock; legal values divide both 128 and 1152.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port seed  input  256  seed material; sampled only in a cycle where reseed=1.
REQ-005 SHALL have port reseed  input  1  one-cycle reseed request.
REQ-006 SHALL have port reseed_ack  output  1  one-cycle pulse when warmup for the latest seed completes.
REQ-007 SHALL have port rdi_ready  input  1  one-cycle request for one new 128-bit word.
REQ-008 SHALL have port rdi_valid  output  1  one-cycle pulse marking a new rdi_data word.
REQ-009 SHALL have port rdi_data  output  128  keystream word; held stable from its rdi_valid until the next rdi_valid.

Function
REQ-010 SHALL implement Trivium with 288-bit state s1..s288.
- Per round: t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
- Then t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69.
- Shift in: t3->s1, t1->s94, t2->s178.
REQ-011 SHALL derive key K[80] = seed[79:0] ^ seed[239:160] and IV[80] = seed[159:80] ^ {64'b0, seed[255:240]}, with K1/IV1 = bit 0.
REQ-012 SHALL load state on reseed as follows:
- s1..s80 = K, s81..s93 = 0.
- s94..s173 = IV, s174..s177 = 0.
- s178..s285 = 0, s286..s288 = 1.
REQ-013 SHALL run 1152 warmup rounds (1152/UNROLL cycles, 18 at default) discarding z.
REQ-014 SHALL pack output bits so that the first keystream bit produced for a word is rdi_data[0] and the 128th is rdi_data[127].
REQ-015 SHALL use FSM states IDLE, WARM, READY, GEN, with transitions:
- IDLE -> WARM on reseed.
- WARM -> READY after the final warmup cycle.
- READY -> GEN on rdi_ready or pending.
- GEN -> READY after 128/UNROLL cycles.
- Any state -> WARM on reseed.
REQ-016 SHALL hold a pending flag:
- Set by rdi_ready whenever the FSM is not in READY.
- Cleared when GEN is entered.
- Not cleared by reseed.
REQ-017 SHALL, when rdi_ready is high in READY in cycle c (default UNROLL), assert rdi_valid in cycle c+3 with the new word.
REQ-018 SHALL, when reseed is high in cycle c, pulse reseed_ack in cycle c+19, with the FSM in READY in that cycle.
REQ-019 SHALL, when reseed arrives in GEN:
- Abort the word without asserting rdi_valid.
- Restart warmup.
- Re-issue the aborted request as pending.
REQ-020 SHALL, when reseed arrives in WARM, reload from the new seed and restart the warmup count; only one reseed_ack is produced, for the last seed.
REQ-021 SHALL, for a rdi_ready in the same cycle as the rdi_valid pulse, start the next word immediately, giving back-to-back words every 3 cycles.
REQ-022 SHALL keep a rdi_ready received in IDLE (never seeded) pending, and serve it after the first warmup.
REQ-023 SHALL treat reseed and rdi_ready in the same cycle as reseed plus pending.
REQ-024 SHALL keep rdi_data unchanged during warmup and aborted generation.

Reset
REQ-025 SHALL, when rst=0, asynchronously force:
- FSM = IDLE.
- Trivium state, pending flag, round counter = 0.
- reseed_ack, rdi_valid = 0.
- rdi_data = 0.
REQ-026 SHALL require a reseed after reset before any word is produced.

Structure
REQ-027 SHALL place TRIV_STATE_W=288, SEED_W=256, RDI_W=128 and WARMUP_ROUNDS=1152 in the shared package newhope_pkg.
REQ-028 SHALL use one combinational sub-module trivium_rounds (UNROLL rounds: state in, state out, UNROLL z bits out), instantiated once.

Verification
REQ-029 SHALL cover: seed=0, reseed in cycle 10 -> reseed_ack only in cycle 29; then rdi_ready in cycle 40 -> rdi_valid only in cycle 43, with data equal to the C golden model.
REQ-030 SHALL cover: rdi_ready in cycle 5 before any seed, reseed in cycle 8 -> reseed_ack in cycle 27, rdi_valid in cycle 30, no earlier valid.
REQ-031 SHALL cover: rdi_ready asserted on every valid cycle -> valid in cycles 43, 46, 49, ..., with 8 consecutive words matching the golden keystream with no skipped bits.
REQ-032 SHALL cover: reseed in GEN cycle 41 -> no valid at 43; ack in cycle 60; valid in cycle 63 with the new-seed first word.
REQ-033 SHALL cover: reseed in cycles 10 and 15 -> single reseed_ack in cycle 34, with keystream from the second seed.
REQ-034 SHALL cover: rst driven low mid-GEN without a clock edge -> outputs zero immediately; after release, no valid until reseed.
